// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage.
// Decodes source/destination register IDs from fetch outputs, reads the
// 15-entry program register file combinationally, and commits valE/valM
// on the rising clock edge.
module decode_writeback #(
    parameter int          NREG     = 15,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Function code only matters to execute; kept on the port for a uniform
    // fetch interface.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    logic [63:0] regs [NREG];

    // Register ID selection from icode; anything unrecognised reads/writes nothing
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RRSP;
                dstE = RRSP;
            end
            I_RET: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RRSP;
                dstE = RRSP;
            end
            I_POPQ: begin
                srcA = RRSP;
                srcB = RRSP;
                dstE = RRSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Asynchronous read ports; ID 0xF matches no entry and reads as zero
    always_comb begin
        valA    = '0;
        valB    = '0;
        dbg_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i))    valA    = regs[i];
            if (srcB == 4'(i))    valB    = regs[i];
            if (dbg_sel == 4'(i)) dbg_val = regs[i];
        end
    end

    // Reset/write-back; valM is checked first so it wins a dstE == dstM collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
        end else if (wb_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (dstM == 4'(i))      regs[i] <= valM;
                else if (dstE == 4'(i)) regs[i] <= valE;
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: expected register contents are
// queued when stimulus is applied and drained through the debug port.
module tb_decode_writeback;

    localparam logic [63:0] RSP0 = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  icode, ifun, rA, rB, dbg_sel;
    logic        cnd, wb_en;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB, dbg_val;
    logic [3:0]  srcA, srcB, dstE, dstM;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] val;
    } exp_t;

    exp_t sb [$];
    int n_chk = 0;
    int n_err = 0;

    decode_writeback #(.NREG(15), .RSP_INIT(RSP0)) dut (
        .clk(clk), .reset(reset), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en),
        .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // one clock edge, inputs may change 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [63:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    // pop every queued expectation and compare through the debug port
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_sel = e.id;
            #1;
            chk($sformatf("R%0d", e.id), dbg_val, e.val);
        end
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        icode = ic;
        rA    = a;
        rB    = b;
    endtask

    initial begin
        reset = 1'b1; icode = 4'h0; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
        cnd = 1'b0; valE = '0; valM = '0; wb_en = 1'b0; dbg_sel = 4'h0;
        step();
        reset = 1'b0;

        // reset state
        for (int i = 0; i < 15; i++) push(4'(i), (i == 4) ? RSP0 : 64'h0);
        drain();
        dbg_sel = 4'hF; #1;
        chk("dbg_none", dbg_val, 64'h0);
        instr(4'hA, 4'h0, 4'hF); #1;
        chk("push_valB", valB, RSP0);
        chk("push_srcB", {60'h0, srcB}, 64'h4);
        chk("push_dstE", {60'h0, dstE}, 64'h4);
        instr(4'hC, 4'h1, 4'h2); #1;
        chk("bad_srcA", {60'h0, srcA}, 64'hF);
        chk("bad_dstE", {60'h0, dstE}, 64'hF);
        chk("bad_valA", valA, 64'h0);

        // irmovq: pre-edge read shows old value
        instr(4'h3, 4'hF, 4'h2); valE = 64'h0A; wb_en = 1'b1; dbg_sel = 4'h2; #1;
        chk("irmov_pre", dbg_val, 64'h0);
        chk("irmov_dstE", {60'h0, dstE}, 64'h2);
        step(); wb_en = 1'b0;
        push(4'h2, 64'h0A);
        drain();

        // OPq
        instr(4'h3, 4'hF, 4'h1); valE = 64'd5; wb_en = 1'b1; step();
        instr(4'h3, 4'hF, 4'h2); valE = 64'd7; step();
        wb_en = 1'b0;
        instr(4'h6, 4'h1, 4'h2); #1;
        chk("op_valA", valA, 64'd5);
        chk("op_valB", valB, 64'd7);
        chk("op_srcA", {60'h0, srcA}, 64'h1);
        chk("op_srcB", {60'h0, srcB}, 64'h2);
        chk("op_dstE", {60'h0, dstE}, 64'h2);
        chk("op_dstM", {60'h0, dstM}, 64'hF);
        valE = 64'd12; wb_en = 1'b1; step(); wb_en = 1'b0;
        push(4'h2, 64'd12); push(4'h1, 64'd5);
        drain();

        // cmovXX
        instr(4'h2, 4'h3, 4'h6); valE = 64'hFF; cnd = 1'b0; wb_en = 1'b1; #1;
        chk("cmov0_dstE", {60'h0, dstE}, 64'hF);
        step(); wb_en = 1'b0;
        push(4'h6, 64'h0);
        drain();
        cnd = 1'b1; wb_en = 1'b1; #1;
        chk("cmov1_dstE", {60'h0, dstE}, 64'h6);
        step(); wb_en = 1'b0; cnd = 1'b0;
        push(4'h6, 64'hFF);
        drain();

        // popq %rsp: valM wins the collision
        instr(4'hB, 4'h4, 4'hF); valE = 64'h108; valM = 64'h55; wb_en = 1'b1; #1;
        chk("pop_srcA", {60'h0, srcA}, 64'h4);
        chk("pop_dstM", {60'h0, dstM}, 64'h4);
        step(); wb_en = 1'b0;
        push(4'h4, 64'h55);
        drain();
        instr(4'hB, 4'h3, 4'hF); valE = 64'h60; valM = 64'h66; wb_en = 1'b1; step(); wb_en = 1'b0;
        push(4'h3, 64'h66); push(4'h4, 64'h60);
        drain();

        // wb_en gating, then reset overriding a pending write
        instr(4'h3, 4'hF, 4'h5); valE = 64'd9; wb_en = 1'b0; step();
        push(4'h5, 64'h0);
        drain();
        wb_en = 1'b1; reset = 1'b1; step();
        reset = 1'b0; wb_en = 1'b0;
        push(4'h5, 64'h0); push(4'h4, RSP0); push(4'h2, 64'h0); push(4'h3, 64'h0);
        drain();
        instr(4'hA, 4'h4, 4'hF); #1;
        chk("rst_push_valA", valA, RSP0);
        chk("rst_push_valB", valB, RSP0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 SEQ decode and write-back stage, directly downstream of fetch.
- Consumes the fetch outputs icode/ifun/rA/rB and holds the 15-entry 64-bit program register file.
- Decode: combinationally selects source and destination register IDs and drives valA/valB to execute.
- Write-back: on the rising clock edge, commits valE (from execute) and valM (from memory) to the decoded destinations.

Parameters:
- NREG, 15, number of architectural registers (IDs 0..14; ID 0xF = RNONE).
- RSP_INIT, 64'h0, value loaded into %rsp (ID 4) on reset; all other registers reset to 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears register file
- icode  input  4  instruction code from fetch
- ifun  input  4  function code from fetch (not used for selection; ignored)
- rA  input  4  register A specifier from fetch
- rB  input  4  register B specifier from fetch
- cnd  input  1  condition result from execute; gates cmovXX write
- valE  input  64  execute result
- valM  input  64  memory read result
- wb_en  input  1  write-back enable; 0 = no register update (halt/stall/invalid)
- valA  output  64  value of srcA register, 0 if srcA=RNONE
- valB  output  64  value of srcB register, 0 if srcB=RNONE
- srcA, srcB, dstE, dstM  output  4 each  decoded register IDs, 0xF = none
- dbg_sel  input  4  debug read select
- dbg_val  output  64  register[dbg_sel], 0 for 0xF

Behaviour:
- Register file: array of 15 x 64-bit flops. Reads are combinational (asynchronous read). Writes occur at the posedge only.
- srcA:
  - rA for icode 2 (rrmovq/cmovXX), 4 (rmmovq), 6 (OPq), A (pushq).
  - 4 for icode 9 (ret), B (popq).
  - else 0xF.
- srcB:
  - rB for icode 4, 5 (mrmovq), 6.
  - 4 for icode 8 (call), 9, A, B.
  - else 0xF.
- dstE:
  - rB for icode 2 when cnd=1; 0xF for icode 2 when cnd=0.
  - rB for icode 3 (irmovq), 6.
  - 4 for icode 8, 9, A, B.
  - else 0xF.
- dstM: rA for icode 5, B; else 0xF.
- Any decoded ID of 0xF means no read (value 0) and no write.
- Write-back at posedge when wb_en=1 and reset=0:
  - R[dstE] <= valE if dstE != 0xF.
  - R[dstM] <= valM if dstM != 0xF.
- Collision dstE == dstM (popq %rsp): valM wins; %rsp = valM after the edge.
- Read-during-write: in the cycle of a write, valA/valB/dbg_val show the pre-edge value; the new value is visible immediately after the edge. Latency is 1 cycle.
- Reset:
  - At posedge with reset=1, all registers become 0 except R[4] = RSP_INIT.
  - Reset overrides any simultaneous write. Asserting reset mid-program discards that cycle's write-back.
  - After reset: valA = valB = 0 unless a source is %rsp (then RSP_INIT); dbg_val follows the same rule.
- Decode of unknown icodes (C..F or 0/1): all IDs = 0xF, no writes, valA = valB = 0.
- No X propagation: every output is defined for every input combination after the first reset.

Test Plan:
- Reset, RSP_INIT=64'h100; then dbg_sel 0..14 -> dbg_val=0 except sel=4 -> 64'h100; icode=A (pushq) -> valB=64'h100.
- irmovq: icode=3, rB=2, valE=64'h0A, wb_en=1, one edge -> R[2]=64'h0A. Same cycle, before the edge, dbg_sel=2 -> 0.
- OPq: R[1]=5, R[2]=7; icode=6, rA=1, rB=2 -> valA=5, valB=7, srcA=1, srcB=2, dstE=2. Drive valE=12, edge -> R[2]=12.
- cmovXX: icode=2, rA=3, rB=6, valE=64'hFF.
  - cnd=0, edge -> R[6] unchanged, dstE=0xF.
  - cnd=1, edge -> R[6]=64'hFF.
- popq %rsp: icode=B, rA=4, valE=64'h108, valM=64'h55, edge -> R[4]=64'h55 (valM wins). popq with rA=3 -> R[3]=valM, R[4]=valE.
- Control: wb_en=0 with icode=3, rB=5, valE=9, edge -> R[5] unchanged. Then reset=1 with a pending write to R[5], edge -> R[5]=0.
